// File: rtl/mult_tb_pkg.sv
// Shared defaults and state encoding for the MBE multiplier result checker.
package mult_tb_pkg;

  localparam int unsigned W_DEF     = 24;
  localparam int unsigned LAT_DEF   = 2;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned PW_DEF    = 2 * W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying a valid bit alongside a data word.
// DEPTH=0 is a combinational pass-through.
module valid_delay_line #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data
);

  if (DEPTH == 0) begin : g_pass
    assign tap_valid = load_valid;
    assign tap_data  = load_data;
  end else begin : g_pipe
    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] dat [DEPTH];

    // Shift valid and data one stage per clock; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= '0;
        for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
      end else begin
        vld[0] <= load_valid;
        dat[0] <= load_data;
        for (int i = 1; i < DEPTH; i++) begin
          vld[i] <= vld[i-1];
          dat[i] <= dat[i-1];
        end
      end
    end

    assign tap_valid = vld[DEPTH-1];
    assign tap_data  = dat[DEPTH-1];
  end

endmodule

// File: rtl/mult_result_checker.sv
// Result sink for the signed MBE multiplier bench: golden product, latency
// match, compare, saturating counters and a drain/report state machine.
module mult_result_checker
  import mult_tb_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VIN,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [2*W-1:0]   P,
  input  logic             END_SIM,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             MISMATCH,
  output logic             DONE,
  output logic             PASS
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned DW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  chk_state_t     state_q, state_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           done_d, pass_d;
  logic           load_valid;
  logic [PW-1:0]  a_ext, b_ext, prod;
  logic           cmp_valid;
  logic [PW-1:0]  cmp_exp;
  logic           cmp_err;

  // Full-precision signed product: sign-extend both operands to 2W bits.
  assign a_ext = {{W{A[W-1]}}, A};
  assign b_ext = {{W{B[W-1]}}, B};
  assign prod  = a_ext * b_ext;

  valid_delay_line #(
    .DEPTH  (LAT),
    .DATA_W (PW)
  ) u_dly (
    .clk        (CLK),
    .rst        (RST),
    .load_valid (load_valid),
    .load_data  (prod),
    .tap_valid  (cmp_valid),
    .tap_data   (cmp_exp)
  );

  assign cmp_err = (P != cmp_exp);

  // Next state, drain countdown and the done/pass values latched on DONE entry.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    done_d     = DONE;
    pass_d     = PASS;
    load_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_valid = VIN;
        if (END_SIM) begin
          state_d = ST_DRAIN;
          drain_d = DW'(LAT);
        end else if (VIN) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        load_valid = VIN;
        if (END_SIM) begin
          state_d = ST_DRAIN;
          drain_d = DW'(LAT);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (ERR_CNT == '0) && (CHK_CNT != '0);
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with the registered DONE/PASS flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      DONE    <= done_d;
      PASS    <= pass_d;
    end
  end

  // Saturating check/error counters and the registered mismatch pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CHK_CNT  <= '0;
      ERR_CNT  <= '0;
      MISMATCH <= 1'b0;
    end else begin
      MISMATCH <= cmp_valid && cmp_err;
      if (cmp_valid) begin
        if (CHK_CNT != '1) CHK_CNT <= CHK_CNT + CNT_W'(1);
        if (cmp_err && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_result_checker.sv
// Directed bench for mult_result_checker: a LAT=2/CNT_W=16 instance and a
// LAT=0/CNT_W=4 instance share the same stimulus.
module tb_mult_result_checker;

  logic        clk;
  logic        rst;
  logic        vin;
  logic [23:0] a;
  logic [23:0] b;
  logic [47:0] p;
  logic        end_sim;

  logic [15:0] chk1, err1;
  logic        mis1, done1, pass1;
  logic [3:0]  chk2, err2;
  logic        mis2, done2, pass2;

  int checks   = 0;
  int failures = 0;

  mult_result_checker #(.W(24), .LAT(2), .CNT_W(16)) u1 (
    .CLK(clk), .RST(rst), .VIN(vin), .A(a), .B(b), .P(p), .END_SIM(end_sim),
    .CHK_CNT(chk1), .ERR_CNT(err1), .MISMATCH(mis1), .DONE(done1), .PASS(pass1)
  );

  mult_result_checker #(.W(24), .LAT(0), .CNT_W(4)) u2 (
    .CLK(clk), .RST(rst), .VIN(vin), .A(a), .B(b), .P(p), .END_SIM(end_sim),
    .CHK_CNT(chk2), .ERR_CNT(err2), .MISMATCH(mis2), .DONE(done2), .PASS(pass2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    vin = 1'b0; a = '0; b = '0; p = '0; end_sim = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_u1(input string tag, input int c, input int e, input logic m,
                          input logic d, input logic ps);
    check({tag, "_chk"},  64'(chk1),  64'(c));
    check({tag, "_err"},  64'(err1),  64'(e));
    check({tag, "_mis"},  64'(mis1),  64'(m));
    check({tag, "_done"}, 64'(done1), 64'(d));
    check({tag, "_pass"}, 64'(pass1), 64'(ps));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #2;
    check_u1("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    check("reset_u2_done", 64'(done2), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Two correct products, then END_SIM.
    vin = 1'b1; a = 24'(3); b = 24'(-5); tick();
    a = 24'h800000; b = 24'h800000; tick();
    vin = 1'b0; a = '0; b = '0; p = 48'hFFFF_FFFF_FFF1; end_sim = 1'b1; tick();
    check_u1("t1_first", 1, 0, 1'b0, 1'b0, 1'b0);
    end_sim = 1'b0; p = 48'h4000_0000_0000; tick();
    check("t1_second_chk", 64'(chk1), 64'd2);
    p = '0; tick();
    check("t1_not_done_yet", 64'(done1), 64'd0);
    tick();
    check_u1("t1_done", 2, 0, 1'b0, 1'b1, 1'b1);
    vin = 1'b1; a = 24'(1); b = 24'(1); p = '0;
    for (int i = 0; i < 4; i++) tick();
    vin = 1'b0;
    check_u1("t1_terminal", 2, 0, 1'b0, 1'b1, 1'b1);

    // Injected error: 7*6 returned as 43; END_SIM held for two cycles.
    do_reset();
    vin = 1'b1; a = 24'(7); b = 24'(6); tick();
    vin = 1'b0; a = '0; b = '0; end_sim = 1'b1; tick();
    p = 48'd43; tick();
    check_u1("t2_mismatch", 1, 1, 1'b1, 1'b0, 1'b0);
    end_sim = 1'b0; p = '0; tick();
    check("t2_mis_pulse_end", 64'(mis1), 64'd0);
    tick();
    check_u1("t2_done", 1, 1, 1'b0, 1'b1, 1'b0);

    // 100 back-to-back vectors A=j, B=-j; END_SIM on the last one.
    do_reset();
    for (int j = 0; j < 102; j++) begin
      vin     = (j < 100);
      a       = (j < 100) ? 24'(j) : '0;
      b       = (j < 100) ? 24'(-j) : '0;
      end_sim = (j == 99);
      p       = (j >= 2) ? 48'(-(longint'(j - 2) * longint'(j - 2))) : '0;
      tick();
    end
    idle_inputs();
    check("t3_chk_before_done", 64'(chk1), 64'd100);
    check("t3_done_not_yet", 64'(done1), 64'd0);
    tick();
    check_u1("t3_done", 100, 0, 1'b0, 1'b1, 1'b1);

    // END_SIM with no vectors.
    do_reset();
    end_sim = 1'b1; tick();
    end_sim = 1'b0; tick();
    check("t4_u2_done_lat0", 64'(done2), 64'd1);
    check("t4_u2_pass", 64'(pass2), 64'd0);
    tick();
    check("t4_u1_not_done", 64'(done1), 64'd0);
    tick();
    check_u1("t4_done", 0, 0, 1'b0, 1'b1, 1'b0);

    // Reset with two vectors still in flight.
    do_reset();
    vin = 1'b1; a = 24'(1); b = 24'(1); tick();
    a = 24'(2); b = 24'(2); tick();
    a = 24'(3); b = 24'(3); p = 48'd1; tick();
    check("t5_pre_chk", 64'(chk1), 64'd1);
    idle_inputs();
    rst = 1'b1;
    #1;
    check_u1("t5_async_rst", 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    vin = 1'b1; a = 24'(5); b = 24'(-3); tick();
    vin = 1'b0; a = '0; b = '0; end_sim = 1'b1; tick();
    check("t5_no_stale", 64'(chk1), 64'd0);
    end_sim = 1'b0; p = 48'hFFFF_FFFF_FFF1; tick();
    check("t5_err_after", 64'(err1), 64'd0);
    p = '0; tick();
    tick();
    check_u1("t5_done", 1, 0, 1'b0, 1'b1, 1'b1);

    // 20 mismatching vectors: 1*1 reported as 0; u2 has 4-bit counters.
    do_reset();
    vin = 1'b1; a = 24'(1); b = 24'(1); p = '0; tick();
    check("t6_u2_mis_pulse", 64'(mis2), 64'd1);
    check("t6_u1_no_mis_yet", 64'(mis1), 64'd0);
    for (int i = 1; i < 20; i++) tick();
    vin = 1'b0; a = '0; b = '0; end_sim = 1'b1; tick();
    end_sim = 1'b0;
    for (int i = 0; i < 10 && !done1; i++) tick();
    check("t6_u1_done_in_budget", 64'(done1), 64'd1);
    check("t6_u2_err_sat", 64'(err2), 64'd15);
    check("t6_u2_chk_sat", 64'(chk2), 64'd15);
    check("t6_u2_pass", 64'(pass2), 64'd0);
    check("t6_u1_err", 64'(err1), 64'd20);
    check("t6_u1_chk", 64'(chk1), 64'd20);
    check("t6_u1_pass", 64'(pass1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
